// File: rtl/transformer_pkg.sv
// Shared element width, saturation limits and the lane adder for the residual stage.
// RESADD_SATURATE_EN selects clamping on overflow; otherwise lanes wrap.
package transformer_pkg;

    localparam int unsigned DEF_DATA_W = 16;

    localparam logic [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

    typedef struct packed {
        logic                  ovf;
        logic [DEF_DATA_W-1:0] sum;
    } sat_res_t;

    // Signed add at DATA_W+1 bits; overflow when the top two bits disagree.
    function automatic sat_res_t sat_add(input logic [DEF_DATA_W-1:0] a,
                                         input logic [DEF_DATA_W-1:0] b);
        logic [DEF_DATA_W:0] s;
        sat_res_t            r;
        s     = {a[DEF_DATA_W-1], a} + {b[DEF_DATA_W-1], b};
        r.ovf = s[DEF_DATA_W] ^ s[DEF_DATA_W-1];
`ifdef RESADD_SATURATE_EN
        if (r.ovf)
            r.sum = s[DEF_DATA_W] ? SAT_MIN : SAT_MAX;
        else
            r.sum = s[DEF_DATA_W-1:0];
`else
        r.sum = s[DEF_DATA_W-1:0];
`endif
        return r;
    endfunction

endpackage

// File: rtl/residual_add_buf_vec_fifo.sv
// Vector-wide FIFO holding skip vectors; storage is deliberately not reset.
module vec_fifo #(
    parameter int unsigned DIM    = 64,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [DIM*DATA_W-1:0]          wr_data,
    output logic [DIM*DATA_W-1:0]          head_c,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DIM*DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    assign head_c = mem[rd_ptr];

endmodule

// File: rtl/residual_add_buf.sv
// Residual add ahead of layer-norm: buffers skip vectors, adds matching sublayer output.
// Build option RESADD_SATURATE_EN clamps overflowing lanes instead of wrapping.
module residual_add_buf
    import transformer_pkg::*;
#(
    parameter int unsigned DIM    = 64,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       skip_valid,
    output logic                       skip_ready,
    input  logic [DIM*DATA_W-1:0]      skip_vec,
    input  logic                       sub_valid,
    output logic                       sub_ready,
    input  logic [DIM*DATA_W-1:0]      sub_vec,
    output logic                       valid_out,
    output logic [DIM*DATA_W-1:0]      out_vec,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       ovf_sticky,
    input  logic                       ovf_clr
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic                  push;
    logic                  pop;
    logic [DIM*DATA_W-1:0] head_c;
    logic [DIM*DATA_W-1:0] sum_c;
    logic                  ovf_any_c;
    sat_res_t              lane_res;

    // Readiness comes only from the registered count: no bypass either way.
    assign skip_ready = (fifo_count < CNT_W'(DEPTH));
    assign sub_ready  = (fifo_count != '0);
    assign push       = skip_valid && skip_ready;
    assign pop        = sub_valid && sub_ready;

    vec_fifo #(
        .DIM    (DIM),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (skip_vec),
        .head_c  (head_c),
        .count   (fifo_count)
    );

    always_comb begin
        sum_c     = '0;
        ovf_any_c = 1'b0;
        lane_res  = '0;
        for (int i = 0; i < int'(DIM); i++) begin
            lane_res = sat_add(head_c[i*DATA_W +: DATA_W], sub_vec[i*DATA_W +: DATA_W]);
            sum_c[i*DATA_W +: DATA_W] = lane_res.sum;
            ovf_any_c = ovf_any_c | lane_res.ovf;
        end
    end

    // Output register and sticky overflow; a new overflow beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            out_vec    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            valid_out <= pop;
            if (pop)
                out_vec <= sum_c;
            if (pop && ovf_any_c)
                ovf_sticky <= 1'b1;
            else if (ovf_clr)
                ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_residual_add_buf.sv
// Directed self-checking bench for residual_add_buf (honours RESADD_SATURATE_EN).
module tb_residual_add_buf;

    localparam int unsigned DIM   = 64;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH+1);

    logic              clk;
    logic              rst_n;
    logic              skip_valid;
    logic              skip_ready;
    logic [DIM*DW-1:0] skip_vec;
    logic              sub_valid;
    logic              sub_ready;
    logic [DIM*DW-1:0] sub_vec;
    logic              valid_out;
    logic [DIM*DW-1:0] out_vec;
    logic [CW-1:0]     fifo_count;
    logic              ovf_sticky;
    logic              ovf_clr;

    int n_checks = 0;
    int n_errors = 0;

    residual_add_buf #(.DIM(DIM), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .skip_valid (skip_valid),
        .skip_ready (skip_ready),
        .skip_vec   (skip_vec),
        .sub_valid  (sub_valid),
        .sub_ready  (sub_ready),
        .sub_vec    (sub_vec),
        .valid_out  (valid_out),
        .out_vec    (out_vec),
        .fifo_count (fifo_count),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DIM*DW-1:0] mk(input int l0, input int l1);
        logic [DIM*DW-1:0] v;
        v          = '0;
        v[DW-1:0]  = DW'(l0);
        v[2*DW-1:DW] = DW'(l1);
        return v;
    endfunction

    function automatic logic [31:0] lane(input int v);
        return {16'h0, 16'(v)};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; skip_valid = 1'b0; sub_valid = 1'b0; ovf_clr = 1'b0;
        skip_vec = '0; sub_vec = '0;
        #2;
        check("rst_count", 32'(fifo_count), 0);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_out_zero", 32'(out_vec == '0), 1);
        check("rst_ovf", 32'(ovf_sticky), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic pairing: 100+20, -5+5
        skip_vec = mk(100, -5); skip_valid = 1'b1;
        tick();
        skip_valid = 1'b0;
        check("t1_count1", 32'(fifo_count), 1);
        sub_vec = mk(20, 5); sub_valid = 1'b1;
        tick();
        sub_valid = 1'b0;
        check("t1_valid", 32'(valid_out), 1);
        check("t1_lane0", 32'(out_vec[DW-1:0]), lane(120));
        check("t1_lane1", 32'(out_vec[2*DW-1:DW]), lane(0));
        check("t1_count0", 32'(fifo_count), 0);
        tick();
        check("t1_strobe_end", 32'(valid_out), 0);
        check("t1_hold", 32'(out_vec[DW-1:0]), lane(120));

        // Fill to DEPTH, reject a fifth push, drain in order
        for (int k = 1; k <= 4; k++) begin
            skip_vec = mk(k, 0); skip_valid = 1'b1;
            tick();
        end
        check("t2_full_count", 32'(fifo_count), 4);
        check("t2_skip_ready", 32'(skip_ready), 0);
        skip_vec = mk(5, 0);
        tick();
        skip_valid = 1'b0;
        check("t2_no_fifth", 32'(fifo_count), 4);
        sub_vec = mk(10, 0); sub_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_pop_valid", 32'(valid_out), 1);
            check("t2_pop_lane0", 32'(out_vec[DW-1:0]), lane(11 + k));
        end
        sub_valid = 1'b0;
        check("t2_empty", 32'(fifo_count), 0);
        tick();
        check("t2_idle", 32'(valid_out), 0);

        // No same-cycle bypass on empty FIFO
        sub_vec = mk(7, 0); sub_valid = 1'b1;
        skip_vec = mk(3, 0); skip_valid = 1'b1;
        check("t3_sub_ready_empty", 32'(sub_ready), 0);
        tick();
        skip_valid = 1'b0;
        check("t3_no_early_valid", 32'(valid_out), 0);
        check("t3_sub_ready", 32'(sub_ready), 1);
        tick();
        sub_valid = 1'b0;
        check("t3_valid", 32'(valid_out), 1);
        check("t3_lane0", 32'(out_vec[DW-1:0]), lane(10));

        // Positive overflow 32767 + 1
        skip_vec = mk(32767, 0); skip_valid = 1'b1;
        tick();
        skip_valid = 1'b0;
        sub_vec = mk(1, 0); sub_valid = 1'b1;
        tick();
        sub_valid = 1'b0;
`ifdef RESADD_SATURATE_EN
        check("t4_pos_ovf", 32'(out_vec[DW-1:0]), lane(32767));
`else
        check("t4_pos_ovf", 32'(out_vec[DW-1:0]), lane(-32768));
`endif
        check("t4_sticky", 32'(ovf_sticky), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_clear", 32'(ovf_sticky), 0);
        skip_vec = mk(32767, 0); skip_valid = 1'b1;
        tick();
        skip_valid = 1'b0;
        sub_vec = mk(1, 0); sub_valid = 1'b1; ovf_clr = 1'b1;
        tick();
        sub_valid = 1'b0; ovf_clr = 1'b0;
        check("t4_set_wins", 32'(ovf_sticky), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t4_clear2", 32'(ovf_sticky), 0);

        // Negative overflow -32768 + -1
        skip_vec = mk(-32768, 0); skip_valid = 1'b1;
        tick();
        skip_valid = 1'b0;
        sub_vec = mk(-1, 0); sub_valid = 1'b1;
        tick();
        sub_valid = 1'b0;
`ifdef RESADD_SATURATE_EN
        check("t5_neg_ovf", 32'(out_vec[DW-1:0]), lane(-32768));
`else
        check("t5_neg_ovf", 32'(out_vec[DW-1:0]), lane(32767));
`endif
        check("t5_sticky", 32'(ovf_sticky), 1);

        // Steady push+pop at count 3 with pointer wrap
        for (int k = 1; k <= 3; k++) begin
            skip_vec = mk(k, 0); skip_valid = 1'b1;
            tick();
        end
        check("t6_fill", 32'(fifo_count), 3);
        sub_vec = mk(100, 0); sub_valid = 1'b1;
        for (int j = 0; j < 8; j++) begin
            skip_vec = mk(4 + j, 0);
            tick();
            check("t6_count", 32'(fifo_count), 3);
            check("t6_order", 32'(out_vec[DW-1:0]), lane(101 + j));
        end
        skip_valid = 1'b0;
        tick();
        check("t6_tail_valid", 32'(valid_out), 1);
        check("t6_tail", 32'(out_vec[DW-1:0]), lane(109));

        // Asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        sub_valid = 1'b0;
        check("t7_rst_valid", 32'(valid_out), 0);
        check("t7_rst_count", 32'(fifo_count), 0);
        check("t7_rst_out", 32'(out_vec == '0), 1);
        check("t7_rst_ovf", 32'(ovf_sticky), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_skip_ready", 32'(skip_ready), 1);
        check("t7_sub_ready", 32'(sub_ready), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/residual_add_buf.md
Name: residual_add_buf

Overview:
- Residual-connection stage directly upstream of the layer-norm stage.
- Buffers skip (residual) vectors in a small vector FIFO until the matching sublayer output vector arrives.
- Adds the two element-wise and emits a registered sum vector with a one-cycle valid strobe.
- The downstream normaliser has no backpressure, so the output side is valid-only.

Parameters:
- DIM, 64, vector length in elements
- DATA_W, 16, signed element width
- DEPTH, 4, skip FIFO depth in vectors; power of two, >= 2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- skip_valid  in  1  skip vector offered
- skip_ready  out  1  FIFO can accept a skip vector
- skip_vec  in  DATA_W x DIM  signed residual vector
- sub_valid  in  1  sublayer output vector offered
- sub_ready  out  1  a buffered skip vector is available to pair
- sub_vec  in  DATA_W x DIM  signed sublayer output vector
- valid_out  out  1  single-cycle strobe, out_vec valid
- out_vec  out  DATA_W x DIM  signed sum vector
- fifo_count  out  $clog2(DEPTH+1)  skip vectors currently buffered
- ovf_sticky  out  1  some lane overflowed since last clear
- ovf_clr  in  1  synchronous clear of ovf_sticky

Behaviour:
- One clock (clk); reset asynchronous active-low (rst_n).
- Reset: pointers, fifo_count, valid_out, out_vec (all lanes 0) and ovf_sticky all go to 0.
  - FIFO storage is not reset.
  - Reset mid-operation discards all buffered vectors and any in-flight output.
- skip_ready = (fifo_count < DEPTH), purely from registered count; no full-with-pop pass-through.
- sub_ready = (fifo_count != 0); no same-cycle bypass.
  - A skip vector pushed in cycle N is poppable at cycle N+1 at the earliest.
- Push: skip_valid && skip_ready; write skip_vec at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: sub_valid && sub_ready; read head at rd_ptr; rd_ptr increments modulo DEPTH.
- Simultaneous push and pop: both occur and fifo_count is unchanged. Legal at any count 1..DEPTH-1, and at DEPTH only if skip_ready was high (it is not).
- Ordering is strict FIFO: the k-th popped skip vector pairs with the k-th accepted sub_vec.
- Arithmetic per lane i:
  - sum_i = sext(skip_i) + sext(sub_i) at DATA_W+1 bits.
  - Overflow when the two MSBs of sum_i differ.
- Latency: the pop cycle registers the result, so valid_out is high the following cycle for exactly one cycle. Back-to-back pops give back-to-back strobes.
- out_vec holds its last value when valid_out is low.
- ovf_sticky:
  - Set in the cycle after a pop in which any lane overflows.
  - ovf_clr clears it.
  - If set and clear coincide, set wins.
- Handshake protocol rule: valid, once asserted, holds data stable until accepted. The block does not check this.

Optional Feature:
- Macro RESADD_SATURATE_EN.
- Defined: overflowing lanes clamp to +(2^(DATA_W-1)-1) or -(2^(DATA_W-1)) according to the sign of sum_i.
- Undefined: lanes wrap, i.e. the low DATA_W bits of sum_i.
- ovf_sticky behaviour is identical in both builds.

Decomposition:
- transformer_pkg holds:
  - the DATA_W default
  - localparams SAT_MAX / SAT_MIN
  - function sat_add(a,b) returning a DATA_W result plus overflow bit, with wrap/saturate selected by the macro
- One sub-module, vec_fifo: DIM-wide vector FIFO with wr/rd pointers and count, parameterised DEPTH, DIM, DATA_W.
- The adder array and output register stay in residual_add_buf.

Test Plan:
- Reset, then push skip lane0=100, lane1=-5; one cycle later sub lane0=20, lane1=5 -> next cycle valid_out=1, out lane0=120, lane1=0; fifo_count 1 -> 0.
- Push 4 skip vectors (values 1,2,3,4 in lane0) with sub_valid low -> fifo_count=4, skip_ready=0, 5th push not accepted. Then 4 pops with sub lane0=10 -> outputs 11,12,13,14 on consecutive cycles.
- sub_valid high with FIFO empty, skip pushed the same cycle -> sub_ready=0 that cycle, pop next cycle, valid_out one cycle later.
- Lane0 32767 + 1:
  - with RESADD_SATURATE_EN -> 32767
  - without -> -32768
  - ovf_sticky=1 in both; ovf_clr asserted alone -> 0 next cycle; ovf_clr concurrent with a new overflow -> stays 1.
- Lane0 -32768 + -1 with saturate build -> -32768, ovf_sticky=1.
- Fill 3 vectors, continuous push+pop for 8 cycles -> fifo_count stays 3, pointers wrap, pairing order preserved. Assert rst_n low mid-stream -> valid_out, fifo_count and out_vec go to 0 immediately; skip_ready=1 after release.
